// File: rtl/xadac_pkg.sv
// Shared types and functions for the xadac coprocessor protocol.
// DecReqT/DecRspT carry the decode handshake; ExeReqT/ExeRspT carry execution.
// decode() claims custom-0 opcodes; execute() implements a small ALU selected by op.
package xadac_pkg;

  localparam int unsigned XadacDefLatency = 3;
  localparam logic [6:0]  XadacOpcode     = 7'h0B;

  typedef struct packed {
    logic [31:0] instr;
  } DecReqT;

  typedef struct packed {
    logic       accept;
    logic [2:0] op;
    logic [4:0] rd;
  } DecRspT;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ExeReqT;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ExeRspT;

  // Foreign opcodes decode to all-zero (not accepted).
  function automatic DecRspT decode(DecReqT req);
    DecRspT rsp;
    rsp = '0;
    if (req.instr[6:0] == XadacOpcode) begin
      rsp.accept = 1'b1;
      rsp.op     = req.instr[14:12];
      rsp.rd     = req.instr[11:7];
    end
    return rsp;
  endfunction

  function automatic ExeRspT execute(ExeReqT req);
    ExeRspT rsp;
    rsp.rd = req.rd;
    unique case (req.op)
      3'd0:    rsp.data = req.rs1 + req.rs2;
      3'd1:    rsp.data = req.rs1 - req.rs2;
      3'd2:    rsp.data = req.rs1 ^ req.rs2;
      3'd3:    rsp.data = req.rs1 & req.rs2;
      3'd4:    rsp.data = req.rs1 | req.rs2;
      3'd5:    rsp.data = req.rs1 << req.rs2[4:0];
      3'd6:    rsp.data = req.rs1 >> req.rs2[4:0];
      default: rsp.data = 32'(req.rs1[15:0]) * 32'(req.rs2[15:0]);
    endcase
    return rsp;
  endfunction

endpackage

// File: rtl/xadac_if.sv
// xadac protocol bundle: decode and execute request/response channels,
// each a valid/ready handshake. mst = core side, slv = coprocessor side.
interface xadac_if;
  import xadac_pkg::*;

  logic   dec_req_valid;
  logic   dec_req_ready;
  DecReqT dec_req;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  DecRspT dec_rsp;

  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeReqT exe_req;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;
  ExeRspT exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_rsp_fifo.sv
// Response FIFO, no fall-through: data pushed while empty is readable next cycle.
// Ports: clk_i/rst_ni, push+wdata, pop, rdata (head), full, empty, count.
// Pointers wrap at DEPTH so non-power-of-2 depths are legal.
module xadac_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  T                wdata,
  input  logic            pop,
  output T                rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));

endmodule

// File: rtl/xadac_slv_engine.sv
// Slave end of the xadac protocol. Decode requests get a one-cycle registered
// decode() result; execute requests flow through LATENCY-1 stage registers into
// a response FIFO. exe_req_ready is credit-based on occupancy so a result always
// finds a FIFO slot. Ports: clk_i, rst_ni, slv (xadac_if.slv), busy_o.
module xadac_slv_engine
  import xadac_pkg::*;
#(
  parameter int unsigned LATENCY = XadacDefLatency,
  parameter int unsigned DEPTH   = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  xadac_if.slv   slv,
  output logic   busy_o
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  // Decode path
  logic   dec_vld_q, dec_acc;
  DecRspT dec_rsp_q;

  assign slv.dec_req_ready = rst_ni && (!dec_vld_q || slv.dec_rsp_ready);
  assign dec_acc           = slv.dec_req_valid && slv.dec_req_ready;
  assign slv.dec_rsp_valid = dec_vld_q;
  assign slv.dec_rsp       = dec_rsp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_vld_q <= 1'b0;
      dec_rsp_q <= '0;
    end else if (dec_acc) begin
      dec_vld_q <= 1'b1;
      dec_rsp_q <= decode(slv.dec_req);
    end else if (slv.dec_rsp_ready) begin
      dec_vld_q <= 1'b0;
    end
  end

  // Exe path
  logic [OccW-1:0] occ_q, occ_d, inflight, fifo_cnt;
  logic            exe_acc, exe_pop, push, fifo_full, fifo_empty;
  ExeRspT          push_data;

  // Same-cycle pop is deliberately not credited: keeps ready off exe_rsp_ready.
  assign slv.exe_req_ready = rst_ni && (occ_q < OccW'(DEPTH));
  assign exe_acc           = slv.exe_req_valid && slv.exe_req_ready;
  assign exe_pop           = slv.exe_rsp_valid && slv.exe_rsp_ready;
  assign slv.exe_rsp_valid = !fifo_empty;

  if (LATENCY > 1) begin : g_pipe
    localparam int unsigned NStg = LATENCY - 1;
    logic [NStg-1:0] vld_q;
    ExeRspT          res_q [NStg];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int i = 0; i < NStg; i++) res_q[i] <= '0;
      end else begin
        vld_q[0] <= exe_acc;
        if (exe_acc) res_q[0] <= execute(slv.exe_req);
        for (int i = 1; i < NStg; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) res_q[i] <= res_q[i-1];
        end
      end
    end

    assign push      = vld_q[NStg-1];
    assign push_data = res_q[NStg-1];
    assign inflight  = OccW'($countones(vld_q));
  end else begin : g_direct
    assign push      = exe_acc;
    assign push_data = execute(slv.exe_req);
    assign inflight  = '0;
  end

  xadac_rsp_fifo #(
    .DEPTH (DEPTH),
    .T     (ExeRspT)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (push_data),
    .pop    (exe_pop),
    .rdata  (slv.exe_rsp),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  always_comb begin
    occ_d = occ_q;
    if (exe_acc && !exe_pop)      occ_d = occ_q + OccW'(1);
    else if (!exe_acc && exe_pop) occ_d = occ_q - OccW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) occ_q <= '0;
    else         occ_q <= occ_d;
  end

  assign busy_o = dec_vld_q || (occ_q != '0);

  a_occ_consistent: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(occ_q) == int'(inflight) + int'(fifo_cnt));
  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv.exe_rsp_valid && !slv.exe_rsp_ready) |=> (slv.exe_rsp_valid && $stable(slv.exe_rsp)));
  a_full_no_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_full |-> !slv.exe_req_ready);

endmodule
